// File: rtl/deser_pkg.sv
// Shared definitions for the deserializer slice.
//   deser_state_e : FSM states (IDLE waits for a start bit, SHIFT collects bits)
//   deser_cnt_w() : bit-counter width for a given word width
//   CNT_W         : counter width for the default 8-bit word
package deser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_e;

    // The counter must be able to hold the value DATA_WIDTH itself.
    function automatic int deser_cnt_w(input int data_width);
        return $clog2(data_width) + 32'sd1;
    endfunction

    localparam int CNT_W = deser_cnt_w(32'sd8);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
//   push/din/full   : write side; a push while full (and not popping) is ignored
//   pop/dout/empty  : read side; dout always shows the head word when !empty
// A push and a pop may both happen in one cycle, including while full.
// dout, empty and full are all flops, so no input reaches an output
// combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             do_push_s, do_pop_s;

    // Next-state computation: pointers, count, storage and the next head word.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        do_pop_s  = pop && !empty_q;
        // When full, a simultaneous pop frees the slot being written.
        do_push_s = push && (!full_q || do_pop_s);

        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == CW'(0));
        full_d  = (count_d == CW'(DEPTH));

        // Register the word that will be at the head after this edge.
        if (count_d != CW'(0)) begin
            dout_d = mem_d[rd_ptr_d];
        end else begin
            dout_d = dout_q;
        end
    end

    // State registers for storage, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign dout  = dout_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel converter: collects DATA_WIDTH enable-qualified bits
// (MSB first, first bit flagged by start) into words, buffers them in a FIFO
// and presents them on a valid/ready interface.
//   clk, rst_n          : clock, asynchronous active-low reset
//   serial_in/enable/start : serial stream input
//   parallel_out/valid/ready : parallel word output handshake
//   overflow, frame_error : sticky status flags, cleared by clear_errors
module deserializer
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  enable,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overflow,
    output logic                  frame_error,
    input  logic                  clear_errors
);

    localparam int CW = deser_cnt_w(DATA_WIDTH);

    deser_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;
    logic                  push_s, ferr_set_s, drop_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [DATA_WIDTH-1:0] fifo_dout_s;

    assign shifted_s = {shift_q[DATA_WIDTH-2:0], serial_in};

    // FSM next state, shift register, bit counter and error events.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && start) begin
                    shift_d = shifted_s;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end else if (enable) begin
                    // Data bit with no preceding start marker.
                    ferr_set_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (enable && start) begin
                    // Premature start: drop the partial word, begin a new one.
                    ferr_set_s = 1'b1;
                    shift_d    = shifted_s;
                    cnt_d      = CW'(1);
                end else if (enable) begin
                    shift_d = shifted_s;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        push_s  = 1'b1;
                        cnt_d   = CW'(0);
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CW'(0);
            end
        endcase

        // A word is lost only if the FIFO is full and not draining this cycle.
        drop_s = push_s && fifo_full_s && !(valid && ready);

        // New error events take priority over a clear in the same cycle.
        if (ferr_set_s) begin
            ferr_d = 1'b1;
        end else if (clear_errors) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clear_errors) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (shifted_s),
        .full  (fifo_full_s),
        .pop   (ready),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s)
    );

    assign parallel_out = fifo_dout_s;
    assign valid        = !fifo_empty_s;
    assign overflow     = ovf_q;
    assign frame_error  = ferr_q;

endmodule
